pipe_stage_regs: RTL

PIPE_STAGE_REGS -- requirements
Module: pipe_stage_regs
Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_3000, PC value loaded on reset.
REQ-002 SHALL have clk  input  1  rising-edge clock for all state.
REQ-003 SHALL have rst  input  1  asynchronous active-low reset.
REQ-004 SHALL have StallF  input  1  hold PC register.
REQ-005 SHALL have StallD  input  1  hold IF/ID register.
REQ-006 SHALL have FlushD  input  1  bubble IF/ID register (taken branch/jump).
REQ-007 SHALL have FlushE  input  1  bubble ID/EX register.
REQ-008 SHALL have npcF  input  32  next PC from PC-select logic.
REQ-009 SHALL have instrF  input  32  fetched instruction.
REQ-010 SHALL have rsD, rtD, rwD  input  5 each  decode-stage source/destination register numbers.
REQ-011 SHALL have ctrlD  input  8  decode controls: [7] RegWrite, [6] MemtoReg, [5] MemWrite, [4:0] ALU/misc.
REQ-012 SHALL have rdata1D, rdata2D  input  32 each  register-file read data.
REQ-013 SHALL have pcF  output  32  current fetch PC.
REQ-014 SHALL have pcD, instrD  output  32 each  decode-stage PC and instruction.
REQ-015 SHALL have validD, validE  output  1 each  stage holds a real instruction (0 = bubble).
REQ-016 SHALL have rsE, rtE, rwE  output  5 each  execute-stage register numbers, feeding the hazard unit.
REQ-017 SHALL have ctrlE  output  8  execute-stage controls; RegWriteE = ctrlE[7], MemtoRegE = ctrlE[6].
REQ-018 SHALL have rdata1E, rdata2E  output  32 each  execute-stage operands.
REQ-019 SHALL have stall_cnt, flush_cnt  output  16 each  performance counters.
Function
REQ-020 PC: each clk edge, pcF <= npcF unless StallF=1 (hold).
REQ-021 IF/ID: StallD=1 -> hold all D fields; else FlushD=1 -> instrD=0, validD=0, pcD=0; else load pcD<=pcF, instrD<=instrF, validD<=1.
REQ-022 StallD SHALL take priority over FlushD in the same cycle; the flush is not remembered (the branch unit re-asserts it).
REQ-023 ID/EX: FlushE=1 -> rsE, rtE, rwE, ctrlE, rdata1E, rdata2E, validE all 0; else load D-stage inputs, validE<=validD.
REQ-024 ID/EX SHALL NOT stall; a held decode stage with FlushE produces exactly one bubble per stall cycle.
REQ-025 A bubble SHALL never write: ctrlE[7]=0 and ctrlE[5]=0 whenever validE=0.
REQ-026 All outputs SHALL be registered; latency 1 cycle per stage, no combinational input-to-output path.
REQ-027 stall_cnt SHALL increment by 1 on each edge with StallD=1; flush_cnt on each edge with FlushD=1 or FlushE=1 (once per edge); both saturate at 16'hFFFF, no wrap.
Reset
REQ-028 rst=0 SHALL immediately set pcF=RESET_PC and all other outputs, including counters, to 0, regardless of clk or stall/flush inputs.
REQ-029 First edge after rst release SHALL fetch from RESET_PC; validD rises on the first unstalled edge.
Configuration
REQ-030 Macro PIPE_PERF_CNT_EN defined: stall_cnt/flush_cnt implemented per REQ-027.
REQ-031 Macro PIPE_PERF_CNT_EN undefined: stall_cnt/flush_cnt tied to 0, no counter flops; all other behaviour identical.
Verification
REQ-032 Reset release, no stalls, npcF=pcF+4 -> pcF 3000,3004,3008; instrD follows instrF one cycle later, validD=1.
REQ-033 Load-use: StallF=StallD=FlushE=1 for 1 cycle -> pcF, instrD held; validE=0, ctrlE=0; next cycle instruction enters E with validE=1.
REQ-034 StallD=1 and FlushD=1 same edge -> instrD held, validD unchanged.
REQ-035 Assert rst=0 mid-stream between edges -> pcF=32'h0000_3000, validD=validE=0, counters 0 before next edge.
REQ-036 With PIPE_PERF_CNT_EN: 70000 consecutive StallD cycles -> stall_cnt=16'hFFFF; without macro -> stall_cnt=0.

---
 rtl/pipe_stage_regs.sv | 116 +++++++++++
 1 files changed

// File: rtl/pipe_stage_regs.sv
// Pipeline state for a 5-stage core: PC, IF/ID and ID/EX registers with stall/flush control.
// Define PIPE_PERF_CNT_EN to build the saturating stall/flush performance counters.
module pipe_stage_regs #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        StallF,
  input  logic        StallD,
  input  logic        FlushD,
  input  logic        FlushE,
  input  logic [31:0] npcF,
  input  logic [31:0] instrF,
  input  logic [4:0]  rsD,
  input  logic [4:0]  rtD,
  input  logic [4:0]  rwD,
  input  logic [7:0]  ctrlD,
  input  logic [31:0] rdata1D,
  input  logic [31:0] rdata2D,
  output logic [31:0] pcF,
  output logic [31:0] pcD,
  output logic [31:0] instrD,
  output logic        validD,
  output logic        validE,
  output logic [4:0]  rsE,
  output logic [4:0]  rtE,
  output logic [4:0]  rwE,
  output logic [7:0]  ctrlE,
  output logic [31:0] rdata1E,
  output logic [31:0] rdata2E,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt
);

  // A bubble entering E must never write the register file or memory.
  function automatic logic [7:0] kill_writes(input logic [7:0] ctrl, input logic vld);
    return vld ? ctrl : (ctrl & 8'h5F);
  endfunction

  // Fetch stage boundary: PC register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pcF <= RESET_PC;
    end else if (!StallF) begin
      pcF <= npcF;
    end
  end

  // IF/ID boundary: stall outranks flush, and a suppressed flush is dropped
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pcD    <= '0;
      instrD <= '0;
      validD <= 1'b0;
    end else if (!StallD) begin
      if (FlushD) begin
        pcD    <= '0;
        instrD <= '0;
        validD <= 1'b0;
      end else begin
        pcD    <= pcF;
        instrD <= instrF;
        validD <= 1'b1;
      end
    end
  end

  // ID/EX boundary: never stalls, so a held decode stage with FlushE emits one bubble per cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rsE     <= '0;
      rtE     <= '0;
      rwE     <= '0;
      ctrlE   <= '0;
      rdata1E <= '0;
      rdata2E <= '0;
      validE  <= 1'b0;
    end else if (FlushE) begin
      rsE     <= '0;
      rtE     <= '0;
      rwE     <= '0;
      ctrlE   <= '0;
      rdata1E <= '0;
      rdata2E <= '0;
      validE  <= 1'b0;
    end else begin
      rsE     <= rsD;
      rtE     <= rtD;
      rwE     <= rwD;
      ctrlE   <= kill_writes(ctrlD, validD);
      rdata1E <= rdata1D;
      rdata2E <= rdata2D;
      validE  <= validD;
    end
  end

`ifdef PIPE_PERF_CNT_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] cnt, input logic en);
    return (en && (cnt != 16'hFFFF)) ? cnt + 16'd1 : cnt;
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      stall_cnt <= sat_inc(stall_cnt, StallD);
      flush_cnt <= sat_inc(flush_cnt, FlushD | FlushE);
    end
  end
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule
